// File: rtl/gray_seq_ctrl.sv
// Step-enable sequencer for the gray-code counter: continuous, burst and
// single-step modes with a programmable prescaler and a step counter.
module gray_seq_ctrl #(
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned PRE_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 pause,
  input  logic [1:0]           mode,
  input  logic [CNT_WIDTH-1:0] burst_len,
  input  logic [PRE_WIDTH-1:0] prescale,
  output logic                 gray_en,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] steps_done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_PAUSED = 2'b10,
    S_DONE   = 2'b11
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_cont;
  logic [CNT_WIDTH-1:0] r_len;
  logic [PRE_WIDTH-1:0] r_pre;
  logic [PRE_WIDTH-1:0] r_pre_cnt;
  logic [CNT_WIDTH-1:0] r_steps;

  logic                 w_accept;
  logic                 w_tick;
  logic                 w_step;
  logic                 w_last;
  logic                 w_mode_cont;
  logic                 w_mode_burst;
  logic [CNT_WIDTH-1:0] w_steps_inc;

  assign w_mode_cont  = (mode == 2'b00);
  assign w_mode_burst = (mode == 2'b01);
  assign w_accept     = (r_state == S_IDLE) && start;
  assign w_tick       = (r_pre_cnt == r_pre);
  // stop and pause gate the step in the same cycle they are seen
  assign w_step       = (r_state == S_RUN) && w_tick && !pause && !stop;
  assign w_steps_inc  = r_steps + CNT_WIDTH'(1);
  assign w_last       = !r_cont && (w_steps_inc == r_len);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_mode_burst && (burst_len == '0)) w_state_nxt = S_DONE;
          else                                    w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (stop)                 w_state_nxt = S_IDLE;
        else if (pause)           w_state_nxt = S_PAUSED;
        else if (w_step && w_last) w_state_nxt = S_DONE;
      end
      S_PAUSED: begin
        if (stop)        w_state_nxt = S_IDLE;
        else if (!pause) w_state_nxt = S_RUN;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // SINGLE and the reserved mode both become a burst of length one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cont    <= 1'b0;
      r_len     <= '0;
      r_pre     <= '0;
      r_pre_cnt <= '0;
      r_steps   <= '0;
    end else if (w_accept) begin
      r_cont    <= w_mode_cont;
      r_len     <= w_mode_cont  ? '0 :
                   w_mode_burst ? burst_len : CNT_WIDTH'(1);
      r_pre     <= prescale;
      r_pre_cnt <= '0;
      r_steps   <= '0;
    end else if (w_step) begin
      r_pre_cnt <= '0;
      r_steps   <= w_steps_inc;
    end else if ((r_state == S_RUN) && !pause && !stop) begin
      r_pre_cnt <= r_pre_cnt + PRE_WIDTH'(1);
    end
  end

  assign gray_en    = w_step;
  assign busy       = (r_state == S_RUN) || (r_state == S_PAUSED);
  assign done       = (r_state == S_DONE);
  assign steps_done = r_steps;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Scoreboard bench for gray_seq_ctrl: expected gray_en/done cycles are queued
// when a command is issued and popped as the DUT produces pulses.
module tb_gray_seq_ctrl;
  localparam int CW = 4;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          pause = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [CW-1:0] burst_len = '0;
  logic [PW-1:0] prescale = '0;
  logic          gray_en;
  logic          busy;
  logic          done;
  logic [CW-1:0] steps_done;

  gray_seq_ctrl #(.CNT_WIDTH(CW), .PRE_WIDTH(PW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .mode       (mode),
    .burst_len  (burst_len),
    .prescale   (prescale),
    .gray_en    (gray_en),
    .busy       (busy),
    .done       (done),
    .steps_done (steps_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int exp_pulse[$];
  int exp_done[$];

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Pulses are matched against the scoreboard by the cycle they occur in
  always @(negedge clk) begin
    if (rst_n) begin
      if (gray_en) begin
        if (exp_pulse.size() == 0) check_val("gray_en_unexpected", cyc, -1);
        else                       check_val("gray_en_cycle", cyc, exp_pulse.pop_front());
      end
      if (done) begin
        if (exp_done.size() == 0) check_val("done_unexpected", cyc, -1);
        else                      check_val("done_cycle", cyc, exp_done.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) next_cyc();
  endtask

  task automatic sample_at(input int n);
    wait_to(n);
    @(negedge clk);
  endtask

  task automatic issue_start(input logic [1:0] m, input int len, input int pre,
                             output int c);
    next_cyc();
    start     = 1'b1;
    mode      = m;
    burst_len = len[CW-1:0];
    prescale  = pre[PW-1:0];
    c         = cyc;
    next_cyc();
    start     = 1'b0;
    mode      = ~m;
    burst_len = ~burst_len;
    prescale  = ~prescale;
  endtask

  task automatic push_train(input int first, input int period, input int count);
    for (int i = 0; i < count; i++) exp_pulse.push_back(first + i * period);
  endtask

  task automatic check_drained(input string tag);
    check_val({tag, "_pulses_left"}, exp_pulse.size(), 0);
    check_val({tag, "_done_left"}, exp_done.size(), 0);
  endtask

  int c;

  initial begin
    #12;
    check_val("rst_gray_en", gray_en, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_steps", steps_done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // BURST of 3, prescale 0
    issue_start(2'b01, 3, 0, c);
    push_train(c + 1, 1, 3);
    exp_done.push_back(c + 4);
    sample_at(c + 2);
    check_val("b3_busy", busy, 1);
    check_val("b3_steps_mid", steps_done, 1);
    sample_at(c + 6);
    check_val("b3_steps", steps_done, 3);
    check_val("b3_busy_end", busy, 0);
    check_drained("b3");

    // CONT, prescale 2, stop coincident with the 4th tick
    issue_start(2'b00, 0, 2, c);
    push_train(c + 3, 3, 3);
    wait_to(c + 12);
    stop = 1'b1;
    @(negedge clk);
    check_val("stop_gates_tick", gray_en, 0);
    check_val("stop_busy_same", busy, 1);
    next_cyc();
    stop = 1'b0;
    @(negedge clk);
    check_val("stop_busy_next", busy, 0);
    sample_at(c + 16);
    check_val("cont_steps", steps_done, 3);
    check_drained("cont");

    // BURST of 5, prescale 1, pause over a tick for 4 cycles
    issue_start(2'b01, 5, 1, c);
    push_train(c + 2, 2, 2);
    push_train(c + 11, 2, 3);
    exp_done.push_back(c + 16);
    wait_to(c + 6);
    pause = 1'b1;
    sample_at(c + 8);
    check_val("pause_steps", steps_done, 2);
    check_val("pause_busy", busy, 1);
    wait_to(c + 10);
    pause = 1'b0;
    sample_at(c + 18);
    check_val("pause_final_steps", steps_done, 5);
    check_val("pause_final_busy", busy, 0);
    check_drained("pause");

    // BURST of 0: straight to DONE
    issue_start(2'b01, 0, 0, c);
    exp_done.push_back(c + 1);
    sample_at(c + 1);
    check_val("b0_busy", busy, 0);
    sample_at(c + 3);
    check_val("b0_steps", steps_done, 0);
    check_drained("b0");

    // start during RUN is ignored
    issue_start(2'b01, 2, 1, c);
    push_train(c + 2, 2, 2);
    exp_done.push_back(c + 5);
    wait_to(c + 2);
    start = 1'b1; mode = 2'b00; burst_len = 4'd7; prescale = 8'd0;
    next_cyc();
    start = 1'b0;
    sample_at(c + 8);
    check_val("ign_steps", steps_done, 2);
    check_val("ign_busy", busy, 0);
    check_drained("ign");

    // CONT wrap of the 4-bit step counter
    issue_start(2'b00, 0, 0, c);
    push_train(c + 1, 1, 17);
    sample_at(c + 16);
    check_val("wrap_15", steps_done, 15);
    sample_at(c + 17);
    check_val("wrap_0", steps_done, 0);
    check_val("wrap_busy", busy, 1);
    wait_to(c + 18);
    stop = 1'b1;
    @(negedge clk);
    check_val("wrap_1", steps_done, 1);
    next_cyc();
    stop = 1'b0;
    sample_at(c + 20);
    check_val("wrap_busy_end", busy, 0);
    check_drained("wrap");

    // SINGLE and reserved mode
    issue_start(2'b10, 6, 2, c);
    exp_pulse.push_back(c + 3);
    exp_done.push_back(c + 4);
    sample_at(c + 6);
    check_val("single_steps", steps_done, 1);
    issue_start(2'b11, 9, 0, c);
    exp_pulse.push_back(c + 1);
    exp_done.push_back(c + 2);
    sample_at(c + 4);
    check_val("mode11_steps", steps_done, 1);
    check_drained("single");

    // Asynchronous reset in the middle of a burst
    issue_start(2'b01, 10, 0, c);
    push_train(c + 1, 1, 3);
    wait_to(c + 4);
    check_val("pre_rst_gray_en", gray_en, 1);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_gray_en", gray_en, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_done", done, 0);
    check_val("mid_rst_steps", steps_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue_start(2'b01, 2, 0, c);
    push_train(c + 1, 1, 2);
    exp_done.push_back(c + 3);
    sample_at(c + 5);
    check_val("post_rst_steps", steps_done, 2);
    check_val("post_rst_busy", busy, 0);
    check_drained("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
